reorder_buffer: RTL and testbench

//  Circular in-order commit queue feeding register_file. Entries are allocated at

---
 rtl/reorder_buffer_pkg.sv | 59 +++++
 rtl/reorder_buffer_op_class.sv | 22 ++
 rtl/reorder_buffer.sv | 209 ++++++++++++++++++++
 tb/tb_reorder_buffer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : reorder_buffer_pkg
// Purpose : Opcode encoding and op-class helpers shared by the reorder buffer,
//           the decoder and the register file.
// Contents: INST_OP_WIDTH, inst_op_t, OP_* opcode constants,
//           op_is_branch / op_is_store / op_has_rd / op_is_ctrl helpers.
// Revision: 1.0 - initial release
// ============================================================================
package reorder_buffer_pkg;

  localparam int INST_OP_WIDTH = 6;

  typedef logic [INST_OP_WIDTH-1:0] inst_op_t;

  // Each op class is a contiguous code range so that class membership is a
  // cheap range compare.
  localparam inst_op_t OP_NOP   = 6'd0;
  localparam inst_op_t OP_LUI   = 6'd1;
  localparam inst_op_t OP_AUIPC = 6'd2;
  localparam inst_op_t OP_JAL   = 6'd3;
  localparam inst_op_t OP_JALR  = 6'd4;
  localparam inst_op_t OP_BEQ   = 6'd5;
  localparam inst_op_t OP_BNE   = 6'd6;
  localparam inst_op_t OP_BLT   = 6'd7;
  localparam inst_op_t OP_BGE   = 6'd8;
  localparam inst_op_t OP_BLTU  = 6'd9;
  localparam inst_op_t OP_BGEU  = 6'd10;
  localparam inst_op_t OP_LB    = 6'd11;
  localparam inst_op_t OP_LH    = 6'd12;
  localparam inst_op_t OP_LW    = 6'd13;
  localparam inst_op_t OP_LBU   = 6'd14;
  localparam inst_op_t OP_LHU   = 6'd15;
  localparam inst_op_t OP_SB    = 6'd16;
  localparam inst_op_t OP_SH    = 6'd17;
  localparam inst_op_t OP_SW    = 6'd18;
  localparam inst_op_t OP_ADDI  = 6'd19;
  localparam inst_op_t OP_ADD   = 6'd28;

  function automatic logic op_is_branch(input inst_op_t op);
    return (op >= OP_BEQ) && (op <= OP_BGEU);
  endfunction

  function automatic logic op_is_store(input inst_op_t op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

  // Branches and stores never write an architectural register.
  function automatic logic op_has_rd(input inst_op_t op);
    return !(op_is_branch(op) || op_is_store(op));
  endfunction

  // Ops whose resolved next PC must be checked against the prediction.
  function automatic logic op_is_ctrl(input inst_op_t op);
    return op_is_branch(op) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/reorder_buffer_op_class.sv
`default_nettype none
// ============================================================================
// Module  : reorder_buffer_op_class
// Purpose : Combinational opcode classifier used at allocation time.
// Ports   : op      in  opcode
//           has_rd  out op writes a destination register
//           is_ctrl out op is a branch/jump (checked for mispredict)
// Revision: 1.0 - initial release
// ============================================================================
module reorder_buffer_op_class
  import reorder_buffer_pkg::*;
(
  input  inst_op_t op,
  output logic     has_rd,
  output logic     is_ctrl
);

  assign has_rd  = op_has_rd(op);
  assign is_ctrl = op_is_ctrl(op);

endmodule
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module  : reorder_buffer
// Purpose : Circular in-order commit queue. Entries are allocated at dispatch,
//           completed by ALU/LSB writeback, retired in order to the register
//           file; mispredicted control ops raise a one-cycle global flush.
// Ports   : clk/rst/rdy/stall         clock, async reset, global enable, stall
//           dec_*                     allocation request and operand queries
//           alu_* / lsb_*             writeback ports
//           rob_full                  no free entry (combinational)
//           rob_q1_* / rob_q2_*       operand query results (with bypass)
//           rob_rf_*                  registered commit to register file
//           rob_head_id / rob_tail_id head pointer / next allocation id
//           rob_flush / rob_flush_pc  registered flush pulse and redirect PC
// Revision: 1.0 - initial release
// ============================================================================
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_SIZE_WIDTH = 3,
  parameter int XLEN           = 32,
  parameter int REG_CNT_WIDTH  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      stall,
  input  logic                      dec_ready,
  input  inst_op_t                  dec_op,
  input  logic [REG_CNT_WIDTH-1:0]  dec_rd,
  input  logic [XLEN-1:0]           dec_pred_pc,
  input  logic [XLEN-1:0]           dec_pc,
  input  logic [ROB_SIZE_WIDTH-1:0] dec_qid1,
  input  logic [ROB_SIZE_WIDTH-1:0] dec_qid2,
  input  logic                      alu_ready,
  input  logic [ROB_SIZE_WIDTH-1:0] alu_rob_id,
  input  logic [XLEN-1:0]           alu_val,
  input  logic [XLEN-1:0]           alu_next_pc,
  input  logic                      lsb_ready,
  input  logic [ROB_SIZE_WIDTH-1:0] lsb_rob_id,
  input  logic [XLEN-1:0]           lsb_val,
  output logic                      rob_full,
  output logic                      rob_q1_ready,
  output logic [XLEN-1:0]           rob_q1_val,
  output logic                      rob_q2_ready,
  output logic [XLEN-1:0]           rob_q2_val,
  output logic                      rob_rf_enable,
  output logic [REG_CNT_WIDTH-1:0]  rob_rf_rd,
  output logic [XLEN-1:0]           rob_rf_val,
  output logic [ROB_SIZE_WIDTH-1:0] rob_head_id,
  output logic [ROB_SIZE_WIDTH-1:0] rob_tail_id,
  output logic                      rob_flush,
  output logic [XLEN-1:0]           rob_flush_pc
);

  localparam int ROB_SIZE = 1 << ROB_SIZE_WIDTH;
  localparam logic [ROB_SIZE_WIDTH:0] FULL_COUNT = {1'b1, {ROB_SIZE_WIDTH{1'b0}}};

  logic [ROB_SIZE-1:0]      ent_valid;
  logic [ROB_SIZE-1:0]      ent_ready;
  logic [ROB_SIZE-1:0]      ent_ctrl;
  logic [REG_CNT_WIDTH-1:0] ent_rd      [ROB_SIZE];
  logic [XLEN-1:0]          ent_val     [ROB_SIZE];
  logic [XLEN-1:0]          ent_pred_pc [ROB_SIZE];
  logic [XLEN-1:0]          ent_next_pc [ROB_SIZE];

  logic [ROB_SIZE_WIDTH-1:0] head;
  logic [ROB_SIZE_WIDTH-1:0] tail;
  logic [ROB_SIZE_WIDTH:0]   count;      // one extra bit separates full from empty
  logic                      flush_pending;
  logic [XLEN-1:0]           flush_target;

  logic dec_has_rd;
  logic dec_is_ctrl;
  logic alloc_fire;
  logic commit_fire;
  logic commit_mispredict;

  // The instruction PC is carried on the dispatch bus but not needed here.
  logic unused_dec_pc;
  assign unused_dec_pc = ^dec_pc;

  reorder_buffer_op_class u_op_class (
    .op      (dec_op),
    .has_rd  (dec_has_rd),
    .is_ctrl (dec_is_ctrl)
  );

  assign rob_full    = (count == FULL_COUNT);
  assign rob_head_id = head;
  assign rob_tail_id = tail;

  assign alloc_fire  = rdy && dec_ready && !stall && !rob_full && !flush_pending;
  // ent_ready is a register, so a writeback commits no earlier than the next edge.
  assign commit_fire = rdy && !flush_pending && ent_valid[head] && ent_ready[head];
  assign commit_mispredict = ent_ctrl[head] && (ent_next_pc[head] != ent_pred_pc[head]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_valid     <= '0;
      ent_ready     <= '0;
      ent_ctrl      <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        ent_rd[i]      <= '0;
        ent_val[i]     <= '0;
        ent_pred_pc[i] <= '0;
        ent_next_pc[i] <= '0;
      end
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      flush_pending <= 1'b0;
      flush_target  <= '0;
      rob_rf_enable <= 1'b0;
      rob_rf_rd     <= '0;
      rob_rf_val    <= '0;
      rob_flush     <= 1'b0;
      rob_flush_pc  <= '0;
    end else if (rdy) begin
      rob_rf_enable <= 1'b0;
      rob_flush     <= 1'b0;
      if (flush_pending) begin
        // Flush cycle: everything younger than the mispredict is discarded.
        rob_flush     <= 1'b1;
        rob_flush_pc  <= flush_target;
        ent_valid     <= '0;
        ent_ready     <= '0;
        head          <= '0;
        tail          <= '0;
        count         <= '0;
        flush_pending <= 1'b0;
      end else begin
        if (alu_ready && ent_valid[alu_rob_id]) begin
          ent_val[alu_rob_id]     <= alu_val;
          ent_next_pc[alu_rob_id] <= alu_next_pc;
          ent_ready[alu_rob_id]   <= 1'b1;
        end
        if (lsb_ready && ent_valid[lsb_rob_id]) begin
          ent_val[lsb_rob_id]   <= lsb_val;
          ent_ready[lsb_rob_id] <= 1'b1;
        end
        if (commit_fire) begin
          rob_rf_enable   <= 1'b1;
          rob_rf_rd       <= ent_rd[head];
          rob_rf_val      <= ent_val[head];
          ent_valid[head] <= 1'b0;
          ent_ready[head] <= 1'b0;
          head            <= head + 1'b1;
          if (commit_mispredict) begin
            flush_pending <= 1'b1;
            flush_target  <= ent_next_pc[head];
          end
        end
        // Tail entry is invalid before this edge, so a same-cycle writeback to
        // it was already ignored above.
        if (alloc_fire) begin
          ent_valid[tail]   <= 1'b1;
          ent_ready[tail]   <= 1'b0;
          ent_ctrl[tail]    <= dec_is_ctrl;
          ent_rd[tail]      <= dec_has_rd ? dec_rd : '0;
          ent_pred_pc[tail] <= dec_pred_pc;
          tail              <= tail + 1'b1;
        end
        case ({alloc_fire, commit_fire})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Operand queries: registered ready state, bypassed from this cycle's writebacks.
  always_comb begin
    rob_q1_ready = ent_ready[dec_qid1];
    rob_q1_val   = ent_val[dec_qid1];
    if (lsb_ready && (lsb_rob_id == dec_qid1)) begin
      rob_q1_ready = 1'b1;
      rob_q1_val   = lsb_val;
    end
    if (alu_ready && (alu_rob_id == dec_qid1)) begin
      rob_q1_ready = 1'b1;
      rob_q1_val   = alu_val;
    end
    rob_q2_ready = ent_ready[dec_qid2];
    rob_q2_val   = ent_val[dec_qid2];
    if (lsb_ready && (lsb_rob_id == dec_qid2)) begin
      rob_q2_ready = 1'b1;
      rob_q2_val   = lsb_val;
    end
    if (alu_ready && (alu_rob_id == dec_qid2)) begin
      rob_q2_ready = 1'b1;
      rob_q2_val   = alu_val;
    end
  end

`ifdef REORDER_BUFFER_PROTOCOL_CHECKS
  always @(posedge clk) begin
    if (!rst && rdy) begin
      assert (!(dec_ready && !stall && rob_full))
        else $error("reorder_buffer: dec_ready asserted while full");
      assert (!(alu_ready && lsb_ready && (alu_rob_id == lsb_rob_id)))
        else $error("reorder_buffer: ALU and LSB wrote the same entry");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_reorder_buffer
// Purpose : Directed self-checking bench for reorder_buffer. Expected commits
//           are queued at allocation and popped when rob_rf_enable pulses.
// Revision: 1.0 - initial release
// ============================================================================
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rdy, stall, dec_ready;
  inst_op_t    dec_op;
  logic [4:0]  dec_rd;
  logic [31:0] dec_pred_pc, dec_pc;
  logic [2:0]  dec_qid1, dec_qid2;
  logic        alu_ready;
  logic [2:0]  alu_rob_id;
  logic [31:0] alu_val, alu_next_pc;
  logic        lsb_ready;
  logic [2:0]  lsb_rob_id;
  logic [31:0] lsb_val;
  logic        rob_full, rob_q1_ready, rob_q2_ready;
  logic [31:0] rob_q1_val, rob_q2_val;
  logic        rob_rf_enable;
  logic [4:0]  rob_rf_rd;
  logic [31:0] rob_rf_val;
  logic [2:0]  rob_head_id, rob_tail_id;
  logic        rob_flush;
  logic [31:0] rob_flush_pc;

  reorder_buffer #(.ROB_SIZE_WIDTH(3), .XLEN(32), .REG_CNT_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall(stall), .dec_ready(dec_ready),
    .dec_op(dec_op), .dec_rd(dec_rd), .dec_pred_pc(dec_pred_pc), .dec_pc(dec_pc),
    .dec_qid1(dec_qid1), .dec_qid2(dec_qid2),
    .alu_ready(alu_ready), .alu_rob_id(alu_rob_id), .alu_val(alu_val),
    .alu_next_pc(alu_next_pc),
    .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_val(lsb_val),
    .rob_full(rob_full),
    .rob_q1_ready(rob_q1_ready), .rob_q1_val(rob_q1_val),
    .rob_q2_ready(rob_q2_ready), .rob_q2_val(rob_q2_val),
    .rob_rf_enable(rob_rf_enable), .rob_rf_rd(rob_rf_rd), .rob_rf_val(rob_rf_val),
    .rob_head_id(rob_head_id), .rob_tail_id(rob_tail_id),
    .rob_flush(rob_flush), .rob_flush_pc(rob_flush_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  id;
    logic [4:0]  rd;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] planned_val [8];
  logic [2:0]  model_tail;
  int          checks = 0;
  int          passes = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle allocation; the expected commit (rd after zeroing, value the
  // bench will later write back) is queued in program order.
  task automatic alloc(input inst_op_t op, input logic [4:0] rd, input logic [4:0] exp_rd,
                       input logic [31:0] pred, input logic [31:0] val);
    exp_t e;
    dec_ready   = 1'b1;
    dec_op      = op;
    dec_rd      = rd;
    dec_pred_pc = pred;
    dec_pc      = pred - 32'd4;
    tick();
    dec_ready = 1'b0;
    e.id = model_tail; e.rd = exp_rd; e.val = val;
    exp_q.push_back(e);
    planned_val[model_tail] = val;
    model_tail = model_tail + 3'd1;
    check("alloc_tail", rob_tail_id, model_tail);
  endtask

  task automatic wb_alu(input logic [2:0] id, input logic [31:0] next_pc);
    alu_ready = 1'b1; alu_rob_id = id; alu_val = planned_val[id]; alu_next_pc = next_pc;
    tick();
    alu_ready = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  // Commit monitor: every commit pulse must match the oldest queued entry.
  always @(negedge clk) begin
    if (!rst && rob_rf_enable) begin
      if (exp_q.size() == 0) begin
        check("unexpected_commit", 1, 0);
      end else begin
        exp_t       e;
        logic [2:0] cid;
        e   = exp_q.pop_front();
        cid = rob_head_id - 3'd1;
        check("commit_rd", rob_rf_rd, e.rd);
        check("commit_val", rob_rf_val, e.val);
        check("commit_id", cid, e.id);
      end
    end
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; stall = 1'b0; dec_ready = 1'b0; dec_op = OP_NOP;
    dec_rd = '0; dec_pred_pc = '0; dec_pc = '0; dec_qid1 = '0; dec_qid2 = '0;
    alu_ready = 1'b0; alu_rob_id = '0; alu_val = '0; alu_next_pc = '0;
    lsb_ready = 1'b0; lsb_rob_id = '0; lsb_val = '0;
    model_tail = '0;
    for (int i = 0; i < 8; i++) planned_val[i] = '0;

    // Reset state
    repeat (2) tick();
    check("rst_rf_enable", rob_rf_enable, 0);
    check("rst_rf_rd", rob_rf_rd, 0);
    check("rst_rf_val", rob_rf_val, 0);
    check("rst_head", rob_head_id, 0);
    check("rst_tail", rob_tail_id, 0);
    check("rst_full", rob_full, 0);
    check("rst_flush", rob_flush, 0);
    check("rst_flush_pc", rob_flush_pc, 0);
    check("rst_q1_ready", rob_q1_ready, 0);
    rst = 1'b0;

    // Basic ADDI: writeback then commit on the following edge
    alloc(OP_ADDI, 5'd5, 5'd5, 32'h0, 32'h2A);
    wb_alu(3'd0, 32'h0);
    check("wb_no_same_cycle_commit", rob_rf_enable, 0);
    tick();
    check("addi_rf_enable", rob_rf_enable, 1);
    check("addi_rf_rd", rob_rf_rd, 5);
    check("addi_rf_val", rob_rf_val, 32'h2A);
    check("addi_head", rob_head_id, 1);
    tick();
    check("addi_pulse_drop", rob_rf_enable, 0);

    // Stall blocks allocation
    dec_ready = 1'b1; stall = 1'b1; dec_op = OP_ADDI;
    tick();
    check("stall_tail", rob_tail_id, 1);
    dec_ready = 1'b0; stall = 1'b0;

    // Mixed ops written back out of order, with query bypass
    alloc(OP_ADDI, 5'd3, 5'd3, 32'h0,   32'h11);   // id1
    alloc(OP_SW,   5'd9, 5'd0, 32'h0,   32'h22);   // id2, store -> rd 0
    alloc(OP_JAL,  5'd1, 5'd1, 32'h300, 32'h304);  // id3, correctly predicted
    alu_ready = 1'b1; alu_rob_id = 3'd3; alu_val = planned_val[3]; alu_next_pc = 32'h300;
    dec_qid1 = 3'd3; dec_qid2 = 3'd2;
    #1;
    check("bypass_q1_ready", rob_q1_ready, 1);
    check("bypass_q1_val", rob_q1_val, 32'h304);
    check("q2_not_ready", rob_q2_ready, 0);
    tick();
    alu_ready = 1'b0;
    #1;
    check("stored_q1_ready", rob_q1_ready, 1);
    check("stored_q1_val", rob_q1_val, 32'h304);
    lsb_ready = 1'b1; lsb_rob_id = 3'd2; lsb_val = planned_val[2];
    tick();
    lsb_ready = 1'b0;
    check("ooo_no_commit", rob_rf_enable, 0);
    wb_alu(3'd1, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ooo_consecutive", rob_rf_enable, 1);
    end
    tick();
    check("jal_no_flush", rob_flush, 0);
    drain();

    // Mispredicted BEQ
    alloc(OP_BEQ, 5'd7, 5'd0, 32'h104, 32'h1);     // id4
    wb_alu(3'd4, 32'h200);
    tick();
    check("beq_commit", rob_rf_enable, 1);
    check("beq_flush_early", rob_flush, 0);
    tick();
    check("flush_pulse", rob_flush, 1);
    check("flush_pc", rob_flush_pc, 32'h200);
    check("flush_head", rob_head_id, 0);
    check("flush_tail", rob_tail_id, 0);
    check("flush_no_commit", rob_rf_enable, 0);
    model_tail = '0;
    tick();
    check("flush_pulse_drop", rob_flush, 0);
    drain();

    // Fill all 8 entries: tail wraps, full asserts, extra request ignored
    for (int i = 0; i < 8; i++)
      alloc(OP_ADDI, 5'(i + 1), 5'(i + 1), 32'h0, 32'h100 + i);
    check("full_set", rob_full, 1);
    check("full_tail_wrap", rob_tail_id, 0);
    dec_ready = 1'b1; dec_op = OP_ADDI;
    tick();
    check("full_ignore_tail", rob_tail_id, 0);
    check("full_still", rob_full, 1);
    dec_ready = 1'b0;
    // Commit and allocation request on the same cycle while full: commit only
    wb_alu(3'd0, 32'h0);
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    check("full_commit_only_tail", rob_tail_id, 0);
    check("full_cleared", rob_full, 0);
    check("full_commit_pulse", rob_rf_enable, 1);
    wb_alu(3'd1, 32'h0);
    wb_alu(3'd2, 32'h0);   // id1 commits at this edge
    tick();                // id2 commits, ids 3..7 still valid

    // Async reset while a commit pulse is high
    @(negedge clk);
    check("pre_rst_pulse", rob_rf_enable, 1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_rf_enable", rob_rf_enable, 0);
    check("async_rst_head", rob_head_id, 0);
    check("async_rst_tail", rob_tail_id, 0);
    check("async_rst_full", rob_full, 0);
    exp_q.delete();
    model_tail = '0;
    tick();
    rst = 1'b0;
    alloc(OP_ADDI, 5'd6, 5'd6, 32'h0, 32'h77);
    check("post_rst_not_full", rob_full, 0);
    wb_alu(3'd0, 32'h0);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
